// File: rtl/rtl_cnt_dn_bk.sv
// Loadable N-bit down-counter, borrow-in/borrow-out, Brent-Kung prefix borrow detect.
// Latency: 1 cycle from load/bin at an edge to cnt/bout after that edge.
// Backpressure: none; bin is the decrement enable and bout chains into the next stage's bin.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (cnt = 0, bout = 0)
//   load   in   synchronous load strobe, wins over bin
//   din    in   [N-1:0] load value
//   bin    in   borrow-in, subtract 1 when high
//   cnt    out  [N-1:0] registered count
//   bout   out  registered borrow-out, one-cycle pulse on the 0 -> all-ones wrap
module rtl_cnt_dn_bk #(
   parameter int N = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] din,
   input  logic         bin,
   output logic [N-1:0] cnt,
   output logic         bout
);

   localparam int LV = $clog2(N);

   // Brent-Kung prefix AND: result bit j = AND of g[0..j].
   // The up-sweep builds complete prefixes at positions 2^m - 1 and partial
   // block ANDs elsewhere; the down-sweep fills the remaining positions.
   // Positions >= N simply do not exist, so non-power-of-two widths fall out
   // of the loop bounds. Each level touches a position at most once and its
   // source is never written on the same level, so in-place update keeps the
   // tree shape (LV up levels + LV-1 down levels).
   function automatic logic [N-1:0] bk_prefix(input logic [N-1:0] g);
      logic [N-1:0] v;
      v = g;
      for (int l = 1; l <= LV; l++) begin
         for (int j = 0; j < N; j++) begin
            if (((j + 1) % (1 << l)) == 0) begin
               v[j] = v[j] & v[j - (1 << (l - 1))];
            end
         end
      end
      for (int l = LV - 1; l >= 1; l--) begin
         for (int j = 0; j < N; j++) begin
            if ((((j + 1) % (1 << l)) == (1 << (l - 1))) && (j >= (1 << l))) begin
               v[j] = v[j] & v[j - (1 << (l - 1))];
            end
         end
      end
      return v;
   endfunction

   // z[i] is high when every bit below i is zero, i.e. bit i flips on a decrement.
   logic [N:0]   z;
   logic [N-1:0] cnt_nxt;
   logic         brw;

   always_comb begin
      z       = {bk_prefix(~cnt), 1'b1};
      cnt_nxt = cnt ^ ({N{bin}} & z[N-1:0]);
      brw     = bin & z[N];
   end

   // With bin low, cnt_nxt == cnt and brw == 0, so the hold case needs no branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         bout <= 1'b0;
      end else if (load) begin
         cnt  <= din;
         bout <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         bout <= brw;
      end
   end

endmodule

// File: tb/tb_rtl_cnt_dn_bk.sv
module tb_rtl_cnt_dn_bk;

   localparam int NW = 5;
   localparam int W[NW] = '{1, 5, 8, 17, 32};

   logic        clk = 1'b0;
   logic        reset;
   logic        bin_r;
   logic        chain_bin;
   logic        ld[NW];
   logic [31:0] dn[NW];
   logic        bo[NW];
   logic [0:0]  c1;
   logic [4:0]  c5;
   logic [7:0]  c8;
   logic [16:0] c17;
   logic [31:0] c32;
   logic [3:0]  lo_c, hi_c;
   logic        lo_b, hi_b;

   int n_vec = 0;
   int n_err = 0;

   longint mc[NW];
   longint mb[NW];

   always #5 clk = ~clk;

   rtl_cnt_dn_bk #(.N(1))  u_d1  (.clk(clk), .reset(reset), .load(ld[0]), .din(dn[0][0:0]),  .bin(bin_r), .cnt(c1),  .bout(bo[0]));
   rtl_cnt_dn_bk #(.N(5))  u_d5  (.clk(clk), .reset(reset), .load(ld[1]), .din(dn[1][4:0]),  .bin(bin_r), .cnt(c5),  .bout(bo[1]));
   rtl_cnt_dn_bk #(.N(8))  u_d8  (.clk(clk), .reset(reset), .load(ld[2]), .din(dn[2][7:0]),  .bin(bin_r), .cnt(c8),  .bout(bo[2]));
   rtl_cnt_dn_bk #(.N(17)) u_d17 (.clk(clk), .reset(reset), .load(ld[3]), .din(dn[3][16:0]), .bin(bin_r), .cnt(c17), .bout(bo[3]));
   rtl_cnt_dn_bk #(.N(32)) u_d32 (.clk(clk), .reset(reset), .load(ld[4]), .din(dn[4]),       .bin(bin_r), .cnt(c32), .bout(bo[4]));

   rtl_cnt_dn_bk #(.N(4)) u_lo (.clk(clk), .reset(reset), .load(1'b0), .din(4'd0), .bin(chain_bin), .cnt(lo_c), .bout(lo_b));
   rtl_cnt_dn_bk #(.N(4)) u_hi (.clk(clk), .reset(reset), .load(1'b0), .din(4'd0), .bin(lo_b),      .cnt(hi_c), .bout(hi_b));

   function automatic longint obs_cnt(input int k);
      case (k)
         0: return longint'(c1);
         1: return longint'(c5);
         2: return longint'(c8);
         3: return longint'(c17);
         default: return longint'(c32);
      endcase
   endfunction

   task automatic check(input string tag, input longint obs, input longint expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      longint mask;
      longint v_cur, v_prev;
      longint hi_exp, hi_exp_prev;
      logic [16:0] exp_seq[5];

      reset     = 1'b1;
      bin_r     = 1'b1;
      chain_bin = 1'b0;
      for (int k = 0; k < NW; k++) begin
         ld[k] = 1'b0;
         dn[k] = 32'd0;
      end

      // Reset held with bin high: outputs stay at zero.
      #1;
      check("rst_cnt_t0", obs_cnt(3), 0);
      check("rst_bout_t0", longint'(bo[3]), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_cnt", obs_cnt(3), 0);
         check("rst_bout", longint'(bo[3]), 0);
      end

      // First edge after release already decrements and wraps.
      reset = 1'b0;
      step();
      check("rel_wrap_cnt", obs_cnt(3), 17'h1FFFF);
      check("rel_wrap_bout", longint'(bo[3]), 1);
      bin_r = 1'b0;
      step();
      check("hold_cnt", obs_cnt(3), 17'h1FFFF);
      check("hold_bout", longint'(bo[3]), 0);

      // Load 3 then count down through the wrap.
      ld[3] = 1'b1; dn[3] = 32'd3;
      step();
      ld[3] = 1'b0;
      check("load3_cnt", obs_cnt(3), 3);
      check("load3_bout", longint'(bo[3]), 0);
      exp_seq = '{17'h2, 17'h1, 17'h0, 17'h1FFFF, 17'h1FFFE};
      bin_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("dn_cnt", obs_cnt(3), longint'(exp_seq[i]));
         check("dn_bout", longint'(bo[3]), (i == 3) ? 1 : 0);
      end

      // load and bin on the same edge: load wins.
      ld[3] = 1'b1; dn[3] = 32'd0;
      step();
      ld[3] = 1'b0;
      check("prio_cnt", obs_cnt(3), 0);
      check("prio_bout", longint'(bo[3]), 0);
      step();
      check("prio_wrap_cnt", obs_cnt(3), 17'h1FFFF);
      check("prio_wrap_bout", longint'(bo[3]), 1);

      // Async reset between edges, mid-count.
      ld[3] = 1'b1; dn[3] = 32'd1;
      step();
      ld[3] = 1'b0;
      check("arst_load_cnt", obs_cnt(3), 1);
      #2 reset = 1'b1;
      #1;
      check("arst_mid_cnt", obs_cnt(3), 0);
      check("arst_mid_bout", longint'(bo[3]), 0);
      reset = 1'b0;
      step();
      check("arst_resume_cnt", obs_cnt(3), 17'h1FFFF);
      check("arst_resume_bout", longint'(bo[3]), 1);

      // Async reset truncating a bout pulse.
      #2 reset = 1'b1;
      #1;
      check("arst_pulse_cnt", obs_cnt(3), 0);
      check("arst_pulse_bout", longint'(bo[3]), 0);
      reset = 1'b0;
      bin_r = 1'b0;
      step();
      check("arst_pulse_hold", obs_cnt(3), 0);

      // Random compare across widths against an arithmetic model.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int k = 0; k < NW; k++) begin
         mc[k] = 0;
         mb[k] = 0;
      end
      for (int s = 0; s < 3000; s++) begin
         bin_r = ((s % 3) == 0) || ((s % 19) == 0);
         for (int k = 0; k < NW; k++) begin
            ld[k] = ($urandom_range(0, 49) == 0);
            dn[k] = $urandom;
         end
         step();
         for (int k = 0; k < NW; k++) begin
            mask = (64'd1 << W[k]) - 1;
            if (ld[k]) begin
               mc[k] = longint'(dn[k]) & mask;
               mb[k] = 0;
            end else if (bin_r) begin
               mb[k] = (mc[k] == 0) ? 1 : 0;
               mc[k] = (mc[k] - 1) & mask;
            end else begin
               mb[k] = 0;
            end
            check($sformatf("rand_cnt_n%0d", W[k]), obs_cnt(k), mc[k]);
            check($sformatf("rand_bout_n%0d", W[k]), longint'(bo[k]), mb[k]);
         end
      end
      for (int k = 0; k < NW; k++) ld[k] = 1'b0;
      bin_r = 1'b0;

      // Chained pair: 8-bit count whose upper nibble lags by one cycle.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      chain_bin = 1'b1;
      v_cur = 0;
      hi_exp = 0;
      for (int t = 1; t <= 300; t++) begin
         step();
         v_prev = v_cur;
         v_cur = (v_cur - 1) & 255;
         hi_exp_prev = hi_exp;
         hi_exp = v_prev >> 4;
         check("chain_lo", longint'(lo_c), v_cur & 15);
         check("chain_lo_bout", longint'(lo_b), ((v_cur & 15) == 15) ? 1 : 0);
         check("chain_hi", longint'(hi_c), hi_exp);
         check("chain_hi_bout", longint'(hi_b), (hi_exp == 15 && hi_exp_prev == 0) ? 1 : 0);
      end
      chain_bin = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
